// File: rtl/aes_keyexp_iter.sv
// rtl/aes_keyexp_iter.sv - Iterative AES-128/192/256 key expansion with indexed round-key readout
//
// Purpose:
//   Produces the AES key schedule one 32-bit word per clock into a 60-word
//   store. Round keys are read back by round index through a registered port.
//   The store is written only through the expansion loop. The loop operands
//   w[i-1] and w[i-Nk] come from an Nk-deep shift window, so the store needs
//   no read port for expansion.
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous active-high reset
//   start       one-cycle expansion request (sampled with key_len/key_in)
//   key_len     00=128, 01=192, 10=256, 11=illegal
//   key_in      cipher key, byte 0 at [255:248], short keys left-aligned
//   inv_mode    (AES_KEYEXP_INV_KEY_EN only) read equivalent-inverse keys
//   busy        high from the cycle after an accepted start until done
//   done        one-cycle pulse after the last schedule word is written
//   keys_valid  storage holds a complete schedule
//   err         one-cycle pulse for a rejected start
//   rd_round    round-key index 0..Nr
//   rk_out      registered round key w[4r..4r+3], w[4r] at [127:96]
//
// Optional feature macro: AES_KEYEXP_INV_KEY_EN
//   Adds inv_mode. When the latched inv_mode is set, round keys 1..Nr-1
//   pass through InvMixColumns before the rk_out register.

module aes_keyexp_iter #(
  parameter int MAX_KEY_BITS = 256,
  parameter int RIDX_W       = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        key_len,
  input  logic [255:0]      key_in,
`ifdef AES_KEYEXP_INV_KEY_EN
  input  logic              inv_mode,
`endif
  output logic              busy,
  output logic              done,
  output logic              keys_valid,
  output logic              err,
  input  logic [RIDX_W-1:0] rd_round,
  output logic [127:0]      rk_out
);

  localparam int WORDS = 60;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_EXPAND = 2'd2,
    S_FIN    = 2'd3
  } state_t;

  localparam logic [0:255][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[b];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

`ifdef AES_KEYEXP_INV_KEY_EN
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] f);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (f)
      4'h9:    gmul = x8 ^ b;
      4'hb:    gmul = x8 ^ x2 ^ b;
      4'hd:    gmul = x8 ^ x4 ^ b;
      default: gmul = x8 ^ x4 ^ x2;
    endcase
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    inv_mix_col[31:24] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
    inv_mix_col[23:16] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
    inv_mix_col[15:8]  = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
    inv_mix_col[7:0]   = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
  endfunction

  function automatic logic [127:0] inv_mix_cols(input logic [127:0] k);
    return {inv_mix_col(k[127:96]), inv_mix_col(k[95:64]),
            inv_mix_col(k[63:32]), inv_mix_col(k[31:0])};
  endfunction
`endif

  state_t         state_q, state_d;
  logic [1:0]     klen_q, klen_d;
  logic [255:0]   key_q, key_d;
  logic [31:0]    mem_q [0:WORDS-1];
  logic [31:0]    mem_d [0:WORDS-1];
  // win[0] is w[i-1]; win[Nk-1] is w[i-Nk]
  logic [31:0]    win_q [0:7];
  logic [31:0]    win_d [0:7];
  logic [5:0]     i_q, i_d;
  logic [2:0]     wrap_q, wrap_d;
  logic [7:0]     rcon_q, rcon_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           kv_q, kv_d;
  logic [127:0]   rk_q, rk_d;
`ifdef AES_KEYEXP_INV_KEY_EN
  logic           inv_q, inv_d;
`endif

  logic [2:0]     nk_m1;
  logic [5:0]     total_m1;
  int             nr;
  logic           key_ok;
  logic [31:0]    key_w [0:7];
  logic [31:0]    temp, w_back, sub_in, sub_out, temp_f, w_new;
  logic           rot_sel;
  logic [2:0]     src;
  int             rd_r;
  logic [127:0]   fwd;

  // Schedule geometry of the latched key size
  always_comb begin
    nk_m1    = 3'd3;
    total_m1 = 6'd43;
    nr       = 10;
    case (klen_q)
      2'd1: begin nk_m1 = 3'd5; total_m1 = 6'd51; nr = 12; end
      2'd2: begin nk_m1 = 3'd7; total_m1 = 6'd59; nr = 14; end
      default: ;
    endcase
  end

  always_comb begin
    case (key_len)
      2'd0:    key_ok = 1'b1;
      2'd1:    key_ok = (MAX_KEY_BITS >= 192);
      2'd2:    key_ok = (MAX_KEY_BITS >= 256);
      default: key_ok = 1'b0;
    endcase
  end

  always_comb begin
    for (int j = 0; j < 8; j++) begin
      key_w[j] = key_q[255-32*j -: 32];
    end
  end

  // One schedule step; a single SubWord serves both the RotWord and Nk==8 paths
  always_comb begin
    temp = win_q[0];
    case (klen_q)
      2'd1:    w_back = win_q[5];
      2'd2:    w_back = win_q[7];
      default: w_back = win_q[3];
    endcase
    rot_sel = (wrap_q == 3'd0);
    sub_in  = rot_sel ? {temp[23:0], temp[31:24]} : temp;
    sub_out = sub_word(sub_in);
    if (rot_sel) begin
      temp_f = sub_out ^ {rcon_q, 24'h000000};
    end else if (klen_q == 2'd2 && wrap_q == 3'd4) begin
      temp_f = sub_out;
    end else begin
      temp_f = temp;
    end
    w_new = w_back ^ temp_f;
  end

  always_comb begin
    state_d = state_q;
    klen_d  = klen_q;
    key_d   = key_q;
    mem_d   = mem_q;
    win_d   = win_q;
    i_d     = i_q;
    wrap_d  = wrap_q;
    rcon_d  = rcon_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    kv_d    = kv_q;
    src     = 3'd0;
`ifdef AES_KEYEXP_INV_KEY_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (key_ok) begin
            key_d   = key_in;
            klen_d  = key_len;
            kv_d    = 1'b0;
            busy_d  = 1'b1;
            state_d = S_LOAD;
`ifdef AES_KEYEXP_INV_KEY_EN
            inv_d   = inv_mode;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        for (int j = 0; j < 8; j++) begin
          if (3'(j) <= nk_m1) begin
            src      = nk_m1 - 3'(j);
            mem_d[j] = key_w[j];
            win_d[j] = key_w[src];
          end
        end
        i_d     = {3'b000, nk_m1} + 6'd1;
        wrap_d  = 3'd0;
        rcon_d  = 8'h01;
        state_d = S_EXPAND;
      end
      S_EXPAND: begin
        mem_d[i_q] = w_new;
        win_d[0]   = w_new;
        for (int j = 1; j < 8; j++) begin
          win_d[j] = win_q[j-1];
        end
        i_d    = i_q + 6'd1;
        wrap_d = (wrap_q == nk_m1) ? 3'd0 : wrap_q + 3'd1;
        if (rot_sel) begin
          rcon_d = xtime(rcon_q);
        end
        if (i_q == total_m1) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        kv_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read port; indices beyond Nr of the latched key size read as zero
  always_comb begin
    rd_r = int'(rd_round);
    fwd  = '0;
    rk_d = '0;
    if (rd_r <= nr) begin
      for (int k = 0; k < 4; k++) begin
        fwd[127-32*k -: 32] = mem_q[6'(4*rd_r + k)];
      end
      rk_d = fwd;
`ifdef AES_KEYEXP_INV_KEY_EN
      if (inv_q && rd_r >= 1 && rd_r < nr) begin
        rk_d = inv_mix_cols(fwd);
      end
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      klen_q  <= 2'd0;
      key_q   <= '0;
      mem_q   <= '{default: '0};
      win_q   <= '{default: '0};
      i_q     <= 6'd0;
      wrap_q  <= 3'd0;
      rcon_q  <= 8'h01;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      kv_q    <= 1'b0;
      rk_q    <= '0;
`ifdef AES_KEYEXP_INV_KEY_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      klen_q  <= klen_d;
      key_q   <= key_d;
      mem_q   <= mem_d;
      win_q   <= win_d;
      i_q     <= i_d;
      wrap_q  <= wrap_d;
      rcon_q  <= rcon_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      kv_q    <= kv_d;
      rk_q    <= rk_d;
`ifdef AES_KEYEXP_INV_KEY_EN
      inv_q   <= inv_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign keys_valid = kv_q;
  assign rk_out     = rk_q;

endmodule

// File: tb/tb_aes_keyexp_iter.sv
// tb/tb_aes_keyexp_iter.sv - Scoreboard bench for aes_keyexp_iter with FIPS-197 vectors

module tb_aes_keyexp_iter;

  localparam logic [127:0] K128     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R1_128   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R10_128  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [191:0] K192     = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [127:0] R1_192   = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
  localparam logic [127:0] R12_192  = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [255:0] K256     = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] R0_256   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] R1_256   = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] R2_256   = 128'ha573c29fa176c498a97fce93a572c09c;
  localparam logic [127:0] R14_256  = 128'h24fc79ccbf0979e9371ac23c6d68de36;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   key_len = 2'd0;
  logic [255:0] key_in = '0;
  logic [3:0]   rd_round = 4'd0;
  logic         busy, done, keys_valid, err;
  logic [127:0] rk_out;

  logic         s_start = 1'b0;
  logic [1:0]   s_key_len = 2'd0;
  logic [255:0] s_key_in = '0;
  logic [3:0]   s_rd_round = 4'd0;
  logic         s_busy, s_done, s_keys_valid, s_err;
  logic [127:0] s_rk_out;

  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  logic         rd_req = 1'b0;
  logic         rd_pend = 1'b0;
  logic [127:0] rk_exp_q [$];
  string        rk_name_q [$];
  int           done_exp_q [$];
  logic [127:0] m_exp;
  string        m_name;
  int           m_cyc;

  aes_keyexp_iter #(.MAX_KEY_BITS(256), .RIDX_W(4)) u_dut (
    .clock(clock), .reset(reset), .start(start), .key_len(key_len), .key_in(key_in),
    .busy(busy), .done(done), .keys_valid(keys_valid), .err(err),
    .rd_round(rd_round), .rk_out(rk_out)
  );

  aes_keyexp_iter #(.MAX_KEY_BITS(128), .RIDX_W(4)) u_small (
    .clock(clock), .reset(reset), .start(s_start), .key_len(s_key_len), .key_in(s_key_in),
    .busy(s_busy), .done(s_done), .keys_valid(s_keys_valid), .err(s_err),
    .rd_round(s_rd_round), .rk_out(s_rk_out)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc     <= cyc + 1;
    rd_pend <= rd_req;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Monitor: consumes expected read data and done timing as the DUT presents them
  always @(negedge clock) begin
    if (rd_pend) begin
      if (rk_exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rk_unexpected got=%h want=none", rk_out);
      end else begin
        m_exp  = rk_exp_q.pop_front();
        m_name = rk_name_q.pop_front();
        chk(m_name, rk_out, m_exp);
      end
    end
    if (done) begin
      if (done_exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done_unexpected got=cycle %0d want=none", cyc);
      end else begin
        m_cyc = done_exp_q.pop_front();
        chk("done_cycle", 128'(cyc), 128'(m_cyc));
      end
    end
  end

  task automatic issue(input logic [1:0] kl, input logic [255:0] k, input int lat);
    start   = 1'b1;
    key_len = kl;
    key_in  = k;
    @(posedge clock);
    #1;
    done_exp_q.push_back(cyc + lat);
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_start", 128'(busy), 128'(1));
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done && n < 150) begin
      @(negedge clock);
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout got=no_done want=done", nm);
      done_exp_q.delete();
    end else begin
      chk({nm, "_kv"}, 128'(keys_valid), 128'(1));
    end
    @(negedge clock);
    chk({nm, "_busy_end"}, 128'(busy), 128'(0));
  endtask

  task automatic rd(input logic [3:0] r, input logic [127:0] e, input string nm);
    rd_round = r;
    rd_req   = 1'b1;
    rk_exp_q.push_back(e);
    rk_name_q.push_back(nm);
    @(negedge clock);
    rd_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_kv", 128'(keys_valid), 128'(0));
    chk("rst_rk", rk_out, 128'(0));

    // 128-bit key, junk in the ignored LSBs
    issue(2'd0, {K128, 128'hdeadbeefcafef00d0123456789abcdef}, 42);
    wait_done("t128");
    rd(4'd10, R10_128, "r128_10");
    rd(4'd1,  R1_128,  "r128_1");
    rd(4'd0,  K128,    "r128_0");
    rd(4'd11, 128'(0), "r128_11_oob");

    // Illegal key_len: err pulse, no busy, schedule retained
    start   = 1'b1;
    key_len = 2'd3;
    key_in  = K256;
    @(negedge clock);
    start = 1'b0;
    chk("ill_err", 128'(err), 128'(1));
    chk("ill_busy", 128'(busy), 128'(0));
    @(negedge clock);
    chk("ill_err_pulse", 128'(err), 128'(0));
    chk("ill_kv_kept", 128'(keys_valid), 128'(1));
    rd(4'd10, R10_128, "ill_r128_10");

    // 192-bit key with a stray start during EXPAND
    issue(2'd1, {K192, 64'hffffffffffffffff}, 48);
    chk("t192_kv_cleared", 128'(keys_valid), 128'(0));
    repeat (10) @(negedge clock);
    start   = 1'b1;
    key_len = 2'd0;
    key_in  = {K128, 128'h0};
    @(negedge clock);
    start = 1'b0;
    chk("busy_start_no_err", 128'(err), 128'(0));
    chk("busy_start_busy", 128'(busy), 128'(1));
    wait_done("t192");
    rd(4'd12, R12_192,        "r192_12");
    rd(4'd1,  R1_192,         "r192_1");
    rd(4'd0,  K192[191:64],   "r192_0");
    rd(4'd13, 128'(0),        "r192_13_oob");

    // 256-bit key
    issue(2'd2, K256, 54);
    wait_done("t256");
    rd(4'd1,  R1_256,  "r256_1");
    rd(4'd2,  R2_256,  "r256_2");
    rd(4'd14, R14_256, "r256_14");
    rd(4'd0,  R0_256,  "r256_0");
    rd(4'd15, 128'(0), "r256_15_oob");

    // Instance limited to 128-bit keys rejects a 256-bit request
    s_start   = 1'b1;
    s_key_len = 2'd2;
    s_key_in  = K256;
    @(negedge clock);
    s_start = 1'b0;
    chk("max128_err", 128'(s_err), 128'(1));
    chk("max128_busy", 128'(s_busy), 128'(0));
    @(negedge clock);
    chk("max128_err_pulse", 128'(s_err), 128'(0));
    chk("max128_done", 128'(s_done), 128'(0));
    chk("max128_kv", 128'(s_keys_valid), 128'(0));
    chk("max128_rk", s_rk_out, 128'(0));

    // Reset around cycle 20 of a 256-bit run
    issue(2'd2, K256, 54);
    rd_round = 4'd0;
    repeat (19) @(negedge clock);
    chk("pre_rst_rk", rk_out, R0_256);
    chk("pre_rst_busy", 128'(busy), 128'(1));
    reset = 1'b1;
    done_exp_q.delete();
    #1;
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_kv", 128'(keys_valid), 128'(0));
    chk("mid_rst_rk", rk_out, 128'(0));
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_rk", rk_out, 128'(0));

    // Fresh 128-bit run after reset
    issue(2'd0, {K128, 128'h0}, 42);
    wait_done("t128b");
    rd(4'd10, R10_128, "r128b_10");
    rd(4'd0,  K128,    "r128b_0");

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
